// File: rtl/rx_tlp_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_tlp_trigger_pkg
// Brief    : Shared constants and FSM encoding for the RX TLP trigger block.
// Revision : 1.0 - initial release
// ============================================================================
package rx_tlp_trigger_pkg;

    localparam int c_BF           = 9;        // RAM address MSB
    localparam int c_HP_QWORDS    = 262144;   // 2 MB huge page in qwords
    localparam int c_MAX_TLP_QW   = 16;       // largest data TLP payload
    localparam int c_QW_W         = 5;        // width of a 1..16 qword count
    localparam int c_HP_W         = 19;       // width of the huge-page fill count

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRIG    = 2'd1,
        ST_CHG     = 2'd2,
        ST_WAIT_RD = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_occupancy_calc.sv
`default_nettype none
// ============================================================================
// Module   : rx_occupancy_calc
// Brief    : Registered modulo occupancy of the RX RAM and next TLP size.
// Revision : 1.0 - initial release
// ============================================================================
module rx_occupancy_calc
    import rx_tlp_trigger_pkg::*;
#(
    parameter int BF = c_BF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BF+1:0]       i_wr_ptr,
    input  logic [BF+1:0]       i_rd_ptr,
    output logic [BF+1:0]       o_occ,
    output logic [c_QW_W-1:0]   o_n
);

    logic [BF+1:0] r_occ;

    // Wrap bit makes the plain subtraction correct across pointer wrap, full included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= i_wr_ptr - i_rd_ptr;
        end
    end

    assign o_occ = r_occ;
    assign o_n   = (r_occ >= (BF+2)'(c_MAX_TLP_QW)) ? c_QW_W'(c_MAX_TLP_QW)
                                                    : r_occ[c_QW_W-1:0];

endmodule
`default_nettype wire

// File: rtl/rx_tlp_trigger.sv
`default_nettype none
// ============================================================================
// Module   : rx_tlp_trigger
// Brief    : Decides when to emit a data TLP or close the current huge page.
// Revision : 1.0 - initial release
// ============================================================================
module rx_tlp_trigger
    import rx_tlp_trigger_pkg::*;
#(
    parameter int BF        = c_BF,
    parameter int HP_QWORDS = c_HP_QWORDS,
    parameter int TIMEOUT   = 64
) (
    input  logic                trn_clk,
    input  logic                reset,
    input  logic [BF+1:0]       commited_wr_address,
    input  logic [BF+1:0]       commited_rd_address,
    output logic                trigger_tlp,
    input  logic                trigger_tlp_ack,
    output logic                change_huge_page,
    input  logic                change_huge_page_ack,
    output logic                send_last_tlp_change_huge_page,
    output logic [c_QW_W-1:0]   qwords_to_send
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [BF+1:0]      w_occ;
    logic [c_QW_W-1:0]  w_n;
    logic               w_occ_zero;
    logic               w_wr_changed;
    logic               w_want;
    logic [c_HP_W:0]    w_hp_sum;

    state_t             r_state;
    logic [c_HP_W-1:0]  r_hp_used;
    logic [c_CNT_W-1:0] r_idle_cnt;
    logic [BF+1:0]      r_rd_snap;
    logic [BF+1:0]      r_wr_prev;
    logic               r_trigger;
    logic               r_change;
    logic               r_send_last;
    logic [c_QW_W-1:0]  r_qwords;

    rx_occupancy_calc #(.BF(BF)) u_occ (
        .clk      (trn_clk),
        .rst      (reset),
        .i_wr_ptr (commited_wr_address),
        .i_rd_ptr (commited_rd_address),
        .o_occ    (w_occ),
        .o_n      (w_n)
    );

    assign w_occ_zero   = (w_occ == '0);
    assign w_wr_changed = (commited_wr_address != r_wr_prev);
    assign w_want       = !w_occ_zero &&
                          ((w_n == c_QW_W'(c_MAX_TLP_QW)) || (r_idle_cnt == c_CNT_W'(TIMEOUT)));
    assign w_hp_sum     = {1'b0, r_hp_used} + (c_HP_W+1)'(w_n);

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hp_used   <= '0;
            r_idle_cnt  <= '0;
            r_rd_snap   <= '0;
            r_wr_prev   <= '0;
            r_trigger   <= 1'b0;
            r_change    <= 1'b0;
            r_send_last <= 1'b0;
            r_qwords    <= '0;
        end else begin
            r_wr_prev <= commited_wr_address;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_changed || w_occ_zero) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt != c_CNT_W'(TIMEOUT)) begin
                        r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
                    end
                    if (w_want) begin
                        r_idle_cnt <= '0;
                        r_rd_snap  <= commited_rd_address;
                        if (w_hp_sum < (c_HP_W+1)'(HP_QWORDS)) begin
                            r_state     <= ST_TRIG;
                            r_trigger   <= 1'b1;
                            r_qwords    <= w_n;
                            r_send_last <= 1'b0;
                        end else if (w_hp_sum == (c_HP_W+1)'(HP_QWORDS)) begin
                            r_state     <= ST_CHG;
                            r_change    <= 1'b1;
                            r_qwords    <= w_n;
                            r_send_last <= 1'b1;
                        end else begin
                            // Payload would straddle the page: close it empty, retry in the new page.
                            r_state     <= ST_CHG;
                            r_change    <= 1'b1;
                            r_qwords    <= '0;
                            r_send_last <= 1'b0;
                        end
                    end
                end
                ST_TRIG: begin
                    if (r_trigger && trigger_tlp_ack) begin
                        r_trigger <= 1'b0;
                        r_hp_used <= r_hp_used + c_HP_W'(r_qwords);
                        r_state   <= ST_WAIT_RD;
                    end
                end
                ST_CHG: begin
                    if (r_change && change_huge_page_ack) begin
                        r_change  <= 1'b0;
                        r_hp_used <= '0;
                        r_state   <= r_send_last ? ST_WAIT_RD : ST_IDLE;
                    end
                end
                ST_WAIT_RD: begin
                    // Occupancy is stale until the DMA engine commits the read pointer.
                    if (commited_rd_address != r_rd_snap) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign trigger_tlp                    = r_trigger;
    assign change_huge_page               = r_change;
    assign send_last_tlp_change_huge_page = r_send_last;
    assign qwords_to_send                 = r_qwords;

endmodule
`default_nettype wire

// File: tb/tb_rx_tlp_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_tlp_trigger
// Brief    : Scoreboard bench for rx_tlp_trigger with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_tlp_trigger;

    localparam int BF  = 9;
    localparam int HPQ = 64;
    localparam int TO  = 64;

    typedef struct packed {
        logic       chg;
        logic [4:0] q;
        logic       sl;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [BF+1:0] wr;
    logic [BF+1:0] rd;
    logic          trigger_tlp;
    logic          trigger_tlp_ack;
    logic          change_huge_page;
    logic          change_huge_page_ack;
    logic          send_last;
    logic [4:0]    qwords;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    logic prev_t;
    logic prev_c;
    logic [4:0] prev_q;

    rx_tlp_trigger #(.BF(BF), .HP_QWORDS(HPQ), .TIMEOUT(TO)) dut (
        .trn_clk                        (clk),
        .reset                          (reset),
        .commited_wr_address            (wr),
        .commited_rd_address            (rd),
        .trigger_tlp                    (trigger_tlp),
        .trigger_tlp_ack                (trigger_tlp_ack),
        .change_huge_page               (change_huge_page),
        .change_huge_page_ack           (change_huge_page_ack),
        .send_last_tlp_change_huge_page (send_last),
        .qwords_to_send                 (qwords)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic chg, input logic [4:0] q, input logic sl);
        exp_t e;
        e.chg = chg; e.q = q; e.sl = sl;
        exp_q.push_back(e);
    endtask

    // Pops the scoreboard on every rising request edge, sampled on the falling clock edge.
    task automatic monitor();
        exp_t e;
        prev_t = 1'b0; prev_c = 1'b0; prev_q = '0;
        forever begin
            @(negedge clk);
            if (trigger_tlp || change_huge_page) begin
                n_vec++;
                if (trigger_tlp && change_huge_page) begin
                    n_err++;
                    $display("FAIL mutex: trigger_tlp=%0b change_huge_page=%0b, required not both", trigger_tlp, change_huge_page);
                end
            end
            if ((trigger_tlp && !prev_t) || (change_huge_page && !prev_c)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_req: chg=%0b q=%0d sl=%0b, required no request", change_huge_page, qwords, send_last);
                end else begin
                    e = exp_q.pop_front();
                    if (change_huge_page !== e.chg || qwords !== e.q || send_last !== e.sl) begin
                        n_err++;
                        $display("FAIL req: got chg=%0b q=%0d sl=%0b, required chg=%0b q=%0d sl=%0b",
                                 change_huge_page, qwords, send_last, e.chg, e.q, e.sl);
                    end
                end
            end else if ((trigger_tlp && prev_t) || (change_huge_page && prev_c)) begin
                n_vec++;
                if (qwords !== prev_q) begin
                    n_err++;
                    $display("FAIL hold_q: got %0d, required %0d", qwords, prev_q);
                end
            end
            prev_t = trigger_tlp;
            prev_c = change_huge_page;
            prev_q = qwords;
        end
    endtask

    task automatic wait_req(input logic chg, input int maxc, output int cyc_n);
        cyc_n = 0;
        while (!(chg ? change_huge_page : trigger_tlp) && cyc_n < maxc) begin
            cyc();
            cyc_n++;
        end
        n_vec++;
        if (!(chg ? change_huge_page : trigger_tlp)) begin
            n_err++;
            $display("FAIL req_timeout: chg=%0b not seen in %0d cycles, required asserted", chg, maxc);
        end
    endtask

    task automatic ack(input logic chg);
        if (chg) change_huge_page_ack = 1'b1;
        else     trigger_tlp_ack      = 1'b1;
        cyc();
        change_huge_page_ack = 1'b0;
        trigger_tlp_ack      = 1'b0;
        cyc();
    endtask

    task automatic expect_window(input string name, input int c, input int lo, input int hi);
        n_vec++;
        if (c < lo || c > hi) begin
            n_err++;
            $display("FAIL %s: request after %0d cycles, required %0d..%0d", name, c, lo, hi);
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (trigger_tlp || change_huge_page) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL %s: request high in %0d cycles, required 0", name, seen);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr = '0; rd = '0;
        trigger_tlp_ack = 1'b0; change_huge_page_ack = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
    endtask

    // Issues three 16-qword TLPs, leaving hp_used at 48 and rd at 48.
    task automatic fill_48();
        int c;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 5'd16, 1'b0);
            wait_req(1'b0, 10, c);
            ack(1'b0);
            rd = 11'(16 * (i + 1));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : driver
        int c;
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        wr = '0; rd = '0;
        trigger_tlp_ack = 1'b0; change_huge_page_ack = 1'b0;
        fork
            monitor();
        join_none
        do_reset();

        n_vec++;
        if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0 || qwords !== 5'd0) begin
            n_err++;
            $display("FAIL reset_outs: t=%0b c=%0b sl=%0b q=%0d, required all 0", trigger_tlp, change_huge_page, send_last, qwords);
        end
        expect_quiet("idle_empty", 10);

        // Scenario 1: 40 qwords -> 16, 16, then 8 after timeout.
        push(1'b0, 5'd16, 1'b0);
        wr = 11'd40;
        wait_req(1'b0, 10, c);
        ack(1'b0);
        push(1'b0, 5'd16, 1'b0);
        rd = 11'd16;
        wait_req(1'b0, 10, c);
        ack(1'b0);
        push(1'b0, 5'd8, 1'b0);
        rd = 11'd32;
        wait_req(1'b0, 100, c);
        expect_window("s1_timeout", c, 64, 70);
        ack(1'b0);
        rd = 11'd40;
        repeat (3) cyc();

        // Scenario 2: lone partial packet, then a write mid-count restarts it.
        do_reset();
        push(1'b0, 5'd5, 1'b0);
        wr = 11'd5;
        wait_req(1'b0, 100, c);
        expect_window("s2_timeout", c, 64, 70);
        ack(1'b0);
        rd = 11'd5;
        repeat (3) cyc();
        push(1'b0, 5'd6, 1'b0);
        wr = 11'd10;
        repeat (29) cyc();
        wr = 11'd11;
        wait_req(1'b0, 100, c);
        expect_window("s2_restart", c, 64, 70);
        ack(1'b0);
        rd = 11'd11;
        repeat (3) cyc();

        // Scenario 3: wrap bit flips between rd and wr.
        do_reset();
        rd = 11'h7F8; wr = 11'h7F8;
        expect_quiet("s3_empty", 5);
        push(1'b0, 5'd16, 1'b0);
        wr = 11'h008;
        wait_req(1'b0, 10, c);
        ack(1'b0);
        rd = 11'h008;
        repeat (3) cyc();

        // Scenario 4: last TLP exactly fills the page.
        do_reset();
        wr = 11'd68;
        fill_48();
        push(1'b1, 5'd16, 1'b1);
        wait_req(1'b1, 10, c);
        ack(1'b1);
        expect_quiet("s4_wait_rd", 20);
        push(1'b0, 5'd16, 1'b0);
        rd = 11'd64; wr = 11'd84;
        wait_req(1'b0, 10, c);
        ack(1'b0);
        rd = 11'd84;
        repeat (3) cyc();

        // Scenario 5: payload overflows the page -> empty page change, then TLP.
        do_reset();
        wr = 11'd56;
        fill_48();
        push(1'b0, 5'd8, 1'b0);
        wait_req(1'b0, 100, c);
        ack(1'b0);
        push(1'b1, 5'd0, 1'b0);
        push(1'b0, 5'd16, 1'b0);
        rd = 11'd56; wr = 11'd72;
        wait_req(1'b1, 10, c);
        ack(1'b1);
        wait_req(1'b0, 10, c);
        ack(1'b0);
        rd = 11'd72;
        repeat (3) cyc();

        // Scenario 6: reset mid-handshake, late ack ignored, request re-raised.
        do_reset();
        push(1'b0, 5'd16, 1'b0);
        wr = 11'd16;
        wait_req(1'b0, 10, c);
        reset = 1'b1;
        cyc();
        n_vec++;
        if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0 || qwords !== 5'd0) begin
            n_err++;
            $display("FAIL s6_reset_outs: t=%0b c=%0b sl=%0b q=%0d, required all 0", trigger_tlp, change_huge_page, send_last, qwords);
        end
        reset = 1'b0;
        trigger_tlp_ack = 1'b1;
        push(1'b0, 5'd16, 1'b0);
        cyc();
        trigger_tlp_ack = 1'b0;
        wait_req(1'b0, 10, c);
        ack(1'b0);
        rd = 11'd16;
        repeat (5) cyc();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
